// File: rtl/register_file_mp.sv
// register_file_mp: DEPTH x WIDTH register file, one byte-enabled write port, two async read ports, clear sequencer.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
`default_nettype none

module register_file_mp #(
  parameter int                WIDTH     = 32,
  parameter int                DEPTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                ZERO_REG  = 1'b0,
  localparam int               AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_enable,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [AW-1:0]      raddr0,
  output logic [WIDTH-1:0]   rdata0,
  input  logic [AW-1:0]      raddr1,
  output logic [WIDTH-1:0]   rdata1,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               wr_drop
);

  localparam int            NB      = WIDTH / 8;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range, wr_zero, wr_active, wr_accept, wr_drop_nxt;
  logic [WIDTH-1:0] wmerged;
  logic [AW-1:0]    raddr_v [2];
  logic [WIDTH-1:0] rdata_v [2];

  assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
  assign wr_zero     = ZERO_REG && (waddr == '0);
  assign wr_active   = write_enable && (wbe != '0);
  assign wr_accept   = wr_active && (state == IDLE) && wr_in_range && !wr_zero;
  assign wr_drop_nxt = wr_active && ((state != IDLE) || !wr_in_range);

  // Byte-merged write value, shared by the array update and the forwarding path
  always_comb begin
    wmerged = wr_in_range ? mem[waddr] : '0;
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) wmerged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;
  assign rdata0     = rdata_v[0];
  assign rdata1     = rdata_v[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_v[p] = '0;
      if (({1'b0, raddr_v[p]} < DEPTH_W) && !(ZERO_REG && (raddr_v[p] == '0)))
        rdata_v[p] = mem[raddr_v[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (raddr_v[p] == waddr))
        rdata_v[p] = wmerged;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (state == CLEAR) begin
      mem[cnt] <= RESET_VAL;
    end else if (wr_accept) begin
      mem[waddr] <= wmerged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_drop <= wr_drop_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: begin
        clr_busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        clr_busy  = 1'b1;
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed stimulus for register_file_mp checked against a cycle-level reference model.
`default_nettype none

module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [2:0]  raddr0 = '0, raddr1 = '0;
  logic        clr_req = 1'b0;
  logic [31:0] rdata0, rdata1, z_rdata0, z_rdata1;
  logic        clr_busy, clr_done, wr_drop, z_busy, z_done, z_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_mp u_dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  register_file_mp #(.ZERO_REG(1'b1)) u_zr (
    .clk(clk), .rst(rst), .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr0(raddr0), .rdata0(z_rdata0), .raddr1(raddr1), .rdata1(z_rdata1),
    .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done), .wr_drop(z_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..8 = clearing entry phase-1, 9 = done pulse
  logic [31:0] m_mem [8];
  int          m_phase;
  bit          m_drop;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] a);
    logic [31:0] r = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (write_enable && (wbe != 4'h0) && m_phase == 0 && a == waddr) r = merge(r, wdata, wbe);
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      m_phase = 0;
      m_drop  = 1'b0;
    end else begin
      m_drop = write_enable && (wbe != 4'h0) && (m_phase != 0);
      if (m_phase == 0) begin
        if (write_enable) m_mem[waddr] = merge(m_mem[waddr], wdata, wbe);
        if (clr_req) m_phase = 1;
      end else if (m_phase <= 8) begin
        m_mem[m_phase-1] = 32'h0;
        m_phase++;
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("rd0", rdata0, mread(raddr0));
    chk("rd1", rdata1, mread(raddr1));
    chk("busy", 32'(clr_busy), 32'(m_phase != 0));
    chk("done", 32'(clr_done), 32'(m_phase == 9));
    chk("drop", 32'(wr_drop), 32'(m_drop));
    chk("z_rd0", z_rdata0, (raddr0 == 3'd0) ? 32'h0 : mread(raddr0));
    chk("z_rd1", z_rdata1, (raddr1 == 3'd0) ? 32'h0 : mread(raddr1));
    chk("z_drop", 32'(z_drop), 32'(m_drop));
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #2;
    write_enable = 1'b1; waddr = a; wdata = d; wbe = be;
    @(posedge clk); #2;
    write_enable = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2; clr_req = 1'b1;
    @(posedge clk); #2; clr_req = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_at, drops, dones;
    #1 rst = 1'b1;
    #100 rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      raddr0 = 3'(a); raddr1 = 3'(a); #1;
      chk("reset_rd0", rdata0, 32'h0);
      chk("reset_rd1", rdata1, 32'h0);
    end
    chk("reset_busy", 32'(clr_busy), 32'h0);
    chk("reset_drop", 32'(wr_drop), 32'h0);

    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    wr(3'd3, 32'h1234_5678, 4'b0011);
    raddr0 = 3'd3; raddr1 = 3'd3; #1;
    chk("be_rd0", rdata0, 32'hFFFF_5678);
    chk("be_rd1", rdata1, 32'hFFFF_5678);
    wr(3'd3, 32'h0000_0000, 4'h0);
    raddr0 = 3'd3; #1;
    chk("be_zero", rdata0, 32'hFFFF_5678);

    wr(3'd2, 32'h1111_2222, 4'hF);
    @(posedge clk); #2;
    write_enable = 1'b1; waddr = 3'd2; wdata = 32'hDEAD_BEEF; wbe = 4'hF; raddr0 = 3'd2;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rdata0, 32'hDEAD_BEEF);
`else
    chk("byp_same", rdata0, 32'h1111_2222);
`endif
    @(posedge clk); #2; write_enable = 1'b0;
    @(negedge clk);
    chk("byp_next", rdata0, 32'hDEAD_BEEF);

    for (int a = 0; a < 8; a++) wr(3'(a), 32'hA5A5_A5A5, 4'hF);
    pulse_clr();
    busy_cnt = 0; done_at = -1; drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_drop) drops++;
      if (!clr_busy) break;
      busy_cnt++;
      if (clr_done) done_at = busy_cnt;
      if (i == 2) begin #1; write_enable = 1'b1; waddr = 3'd5; wdata = 32'h5555_5555; wbe = 4'hF; end
      if (i == 3) begin #1; write_enable = 1'b0; end
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("clr_done_cycle", 32'(done_at), 32'd9);
    chk("clr_drops", 32'(drops), 32'd1);
    #1;
    for (int a = 0; a < 8; a++) begin
      raddr0 = 3'(a); #1;
      chk("clr_rd", rdata0, 32'h0);
    end

    @(posedge clk); #2;
    write_enable = 1'b1; waddr = 3'd6; wdata = 32'h0000_0077; wbe = 4'hF; clr_req = 1'b1;
    raddr1 = 3'd6;
    @(posedge clk); #2;
    write_enable = 1'b0; clr_req = 1'b0;
    chk("wr_then_clr", rdata1, 32'h0000_0077);
    for (int i = 0; i < 12 && clr_busy; i++) @(negedge clk);
    chk("wr_clr_idle", 32'(clr_busy), 32'h0);
    #1 chk("wr_clr_rd", rdata1, 32'h0);

    wr(3'd4, 32'hA5A5_A5A5, 4'hF);
    wr(3'd7, 32'hA5A5_A5A5, 4'hF);
    pulse_clr();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_busy", 32'(clr_busy), 32'h0);
    for (int a = 0; a < 8; a++) begin
      raddr0 = 3'(a); #1;
      chk("rst_mid_rd", rdata0, 32'h0);
    end
    @(negedge clk); #1 rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (clr_done) dones++;
    end
    chk("rst_mid_nodone", 32'(dones), 32'h0);

    raddr0 = 3'd0;
    wr(3'd0, 32'h0000_0055, 4'hF);
    #1;
    chk("zr_rd0", z_rdata0, 32'h0);
    chk("zr_drop", 32'(z_drop), 32'h0);
    chk("nz_rd0", rdata0, 32'h0000_0055);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
